run_monitor: RTL and testbench
==============================

# run_monitor

Parametrised, multi-channel end-of-test controller for simulation and FPGA-prototype harnesses. It sequences harness reset release, counts cycles, gates waveform dumping to a cycle window, aggregates per-channel success/failure, and applies timeout and per-channel stall watchdogs. It reports a sticky pass/fail verdict, a reason code and a one-cycle finish request. It sits between the top-level test driver and one or more harness instances.

## Interface
- NUM_CH, 4, number of monitored channels (≥1)
- CNT_W, 64, cycle counter and cycle-config width
- HOLDOFF, 8, cycles harness_reset stays high after reset_n deasserts (≥1)
- DRAIN, 16, cycles between all-success and PASS verdict (≥0)
- STALL_W, 16, stall limit/counter width
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- cfg_max_cycles  in  CNT_W  timeout; 0 = disabled
- cfg_dump_start  in  CNT_W  first dump cycle
- cfg_dump_stop  in  CNT_W  first non-dump cycle; 0 = no stop
- cfg_stall_limit  in  STALL_W  progress watchdog; 0 = disabled
- ch_success  in  NUM_CH  per-channel success level/pulse
- ch_failure  in  NUM_CH  per-channel failure level/pulse
- ch_progress  in  NUM_CH  per-channel progress pulse (e.g. retire)
- harness_reset  out  1  active-high reset to harnesses
- dump_en  out  1  waveform dump enable
- cycle_count  out  CNT_W  cycles since reset_n deassert
- done  out  1  sticky verdict valid
- pass  out  1  sticky pass (valid when done)
- reason  out  3  0 none, 1 channel fail, 2 timeout, 3 stall, 4 pass
- fail_ch  out  NUM_CH  latched bitmap of failing/stalled channels
- finish_req  out  1  one-cycle pulse on entering a done state

## Operation
- Reset (reset_n=0 at an edge): state HOLD, harness_reset=1, cycle_count=0, done=0, pass=0, reason=0, fail_ch=0, dump_en=0, finish_req=0, sticky success bits and stall counters cleared. Applies mid-run from any state.
- cycle_count: +1 per edge with reset_n=1; saturates at all-ones.
- HOLD: harness_reset=1 for HOLDOFF cycles, then RUN. Channel inputs ignored in HOLD.
- RUN: each ch_success bit sets a sticky succ[i]. When all succ set → DRAIN (DRAIN=0 → PASS directly).
- DRAIN: counts DRAIN cycles, then PASS. Failure checks remain active.
- Fail checks (RUN and DRAIN), evaluated each cycle with fixed priority:
  - 1: any ch_failure → FAIL, reason=1, fail_ch=ch_failure.
  - 2: cfg_max_cycles≠0 and cycle_count>cfg_max_cycles → FAIL, reason=2, fail_ch=0.
  - 3: stall (see Configuration) → FAIL, reason=3, fail_ch=stalled channels.
  - Fail beats a success completing in the same cycle.
- PASS: done=1, pass=1, reason=4. FAIL: done=1, pass=0. Both terminal until reset. All channel inputs ignored.
- dump_en = (state≠HOLD or cfg_dump_start=0) and cycle_count≥cfg_dump_start and (cfg_dump_stop=0 or cycle_count<cfg_dump_stop) and !done. cfg_dump_start=0 includes the HOLD sequence.

## Timing
- All outputs registered. Verdict flops update on the edge that samples the triggering input; done/finish_req are visible the next cycle.
- A ch_failure sampled at edge N gives done=1 and finish_req=1 after edge N. finish_req is low after edge N+1.
- Timeout: the edge where registered cycle_count=cfg_max_cycles+1 is the triggering edge.
- harness_reset falls after edge HOLDOFF following reset_n deassertion.
- cfg_* are quasi-static; changes take effect on the next evaluation, no synchronisation.

## Configuration
- RUN_MONITOR_STALL_EN defined: one STALL_W saturating counter per channel.
  - The counter is cleared by ch_progress[i] or when succ[i]=1, and counts in RUN/DRAIN otherwise.
  - Stall fires when cfg_stall_limit≠0 and a counter reaches cfg_stall_limit.
- Not defined: no counters; reason 3 never produced; cfg_stall_limit ignored.

## Test plan
- NUM_CH=4, HOLDOFF=8, DRAIN=16. All ch_success rise at cycle 100 → DRAIN, then done=1, pass=1, reason=4 at cycle 117; single finish_req pulse.
- ch_failure=4'b0100 at cycle 50 with ch_success=4'b1111 at the same edge → reason=1, fail_ch=4'b0100, pass=0.
- cfg_max_cycles=200, no success → done at cycle 202, reason=2. Same run with cfg_max_cycles=0 → never done.
- STALL_EN, cfg_stall_limit=10, channel 2 progress stops at cycle 40 while others progress → reason=3, fail_ch=4'b0100. Without the macro → no verdict.
- cfg_dump_start=20, cfg_dump_stop=30 → dump_en high for exactly cycles 20–29. cfg_dump_start=0 → dump_en high through HOLD.
- reset_n pulsed low during DRAIN → all outputs at reset values; harness_reset high for HOLDOFF again; cycle_count restarts at 0.

Source files
------------

// File: rtl/run_monitor.sv
// End-of-test controller: harness reset sequencing, dump window, verdict and timeout.
// Define RUN_MONITOR_STALL_EN to add the per-channel progress (stall) watchdog.
module run_monitor #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 64,
  parameter int HOLDOFF = 8,
  parameter int DRAIN   = 16,
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [CNT_W-1:0]   cfg_max_cycles,
  input  logic [CNT_W-1:0]   cfg_dump_start,
  input  logic [CNT_W-1:0]   cfg_dump_stop,
  input  logic [STALL_W-1:0] cfg_stall_limit,
  input  logic [NUM_CH-1:0]  ch_success,
  input  logic [NUM_CH-1:0]  ch_failure,
  input  logic [NUM_CH-1:0]  ch_progress,
  output logic               harness_reset,
  output logic               dump_en,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               done,
  output logic               pass,
  output logic [2:0]         reason,
  output logic [NUM_CH-1:0]  fail_ch,
  output logic               finish_req
);

  localparam logic [2:0] S_HOLD  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_PASS  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;

  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN > 0) ? DRAIN - 1 : 0);

  logic [2:0]        state, state_nx;
  logic [NUM_CH-1:0] succ, succ_nx, fail_ch_nx, stalled;
  logic [DW-1:0]     drain_cnt, drain_nx;
  logic [CNT_W-1:0]  count_nx;
  logic [2:0]        reason_nx;
  logic              active, timeout, all_succ, done_nx, dump_nx;

  assign active = (state == S_RUN) || (state == S_DRAIN);

`ifdef RUN_MONITOR_STALL_EN
  logic [STALL_W-1:0] stall_cnt [NUM_CH];

  // A channel's counter restarts whenever it shows progress or has already succeeded.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!reset_n || ch_progress[i] || succ[i])
        stall_cnt[i] <= '0;
      else if (active && stall_cnt[i] != '1)
        stall_cnt[i] <= stall_cnt[i] + STALL_W'(1);
    end
  end

  always_comb begin
    stalled = '0;
    for (int i = 0; i < NUM_CH; i++)
      stalled[i] = (cfg_stall_limit != '0) && !succ[i] && (stall_cnt[i] >= cfg_stall_limit);
  end
`else
  logic unused_stall;
  assign unused_stall = ^{ch_progress, cfg_stall_limit};
  assign stalled = '0;
`endif

  always_comb begin
    state_nx   = state;
    succ_nx    = succ;
    drain_nx   = drain_cnt;
    reason_nx  = reason;
    fail_ch_nx = fail_ch;
    count_nx   = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
    timeout    = (cfg_max_cycles != '0) && (cycle_count > cfg_max_cycles);
    all_succ   = &(succ | ch_success);
    case (state)
      S_HOLD: begin
        if (cycle_count >= CNT_W'(HOLDOFF - 1))
          state_nx = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        // Failure sources are checked before any success so a fail always wins the cycle.
        if (ch_failure != '0) begin
          state_nx   = S_FAIL;
          reason_nx  = 3'd1;
          fail_ch_nx = ch_failure;
        end else if (timeout) begin
          state_nx   = S_FAIL;
          reason_nx  = 3'd2;
          fail_ch_nx = '0;
        end else if (stalled != '0) begin
          state_nx   = S_FAIL;
          reason_nx  = 3'd3;
          fail_ch_nx = stalled;
        end else if (state == S_RUN) begin
          succ_nx = succ | ch_success;
          if (all_succ) begin
            drain_nx = '0;
            if (DRAIN == 0) begin
              state_nx  = S_PASS;
              reason_nx = 3'd4;
            end else begin
              state_nx = S_DRAIN;
            end
          end
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nx  = S_PASS;
          reason_nx = 3'd4;
        end else begin
          drain_nx = drain_cnt + DW'(1);
        end
      end
      default: ;
    endcase
    done_nx = (state_nx == S_PASS) || (state_nx == S_FAIL);
    dump_nx = ((state_nx != S_HOLD) || (cfg_dump_start == '0)) &&
              (count_nx >= cfg_dump_start) &&
              ((cfg_dump_stop == '0) || (count_nx < cfg_dump_stop)) && !done_nx;
  end

  // Outputs are registered from the next-state values so they line up with cycle_count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= S_HOLD;
      succ          <= '0;
      drain_cnt     <= '0;
      harness_reset <= 1'b1;
      dump_en       <= 1'b0;
      cycle_count   <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      reason        <= 3'd0;
      fail_ch       <= '0;
      finish_req    <= 1'b0;
    end else begin
      state         <= state_nx;
      succ          <= succ_nx;
      drain_cnt     <= drain_nx;
      harness_reset <= (state_nx == S_HOLD);
      dump_en       <= dump_nx;
      cycle_count   <= count_nx;
      done          <= done_nx;
      pass          <= (state_nx == S_PASS);
      reason        <= reason_nx;
      fail_ch       <= fail_ch_nx;
      finish_req    <= done_nx && !done;
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: directed scenario table, reset-in-drain
// sequence and randomized runs against a cycle-number-based reference model.
module tb_run_monitor;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 64;
  localparam int HOLDOFF = 8;
  localparam int DRAIN   = 16;
  localparam int STALL_W = 16;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [CNT_W-1:0]   cfg_max_cycles, cfg_dump_start, cfg_dump_stop;
  logic [STALL_W-1:0] cfg_stall_limit;
  logic [NUM_CH-1:0]  ch_success, ch_failure, ch_progress;
  logic               harness_reset, dump_en, done, pass, finish_req;
  logic [CNT_W-1:0]   cycle_count;
  logic [2:0]         reason;
  logic [NUM_CH-1:0]  fail_ch;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  run_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .HOLDOFF(HOLDOFF), .DRAIN(DRAIN),
                .STALL_W(STALL_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_max_cycles(cfg_max_cycles), .cfg_dump_start(cfg_dump_start),
    .cfg_dump_stop(cfg_dump_stop), .cfg_stall_limit(cfg_stall_limit),
    .ch_success(ch_success), .ch_failure(ch_failure), .ch_progress(ch_progress),
    .harness_reset(harness_reset), .dump_en(dump_en), .cycle_count(cycle_count),
    .done(done), .pass(pass), .reason(reason), .fail_ch(fail_ch), .finish_req(finish_req)
  );

  // Reference model: everything is expressed in terms of the cycle number.
  longint     m_cyc;
  bit         m_done, m_pass, m_finish, m_dump;
  logic [2:0] m_reason;
  logic [3:0] m_failch, m_succ;
  longint     m_pass_at;
  longint     m_last_clear [NUM_CH];

  task automatic model_step(input logic rn, input logic [3:0] s, input logic [3:0] f,
                            input logic [3:0] p);
    bit         was_done;
    logic [3:0] stl, old_succ;
    was_done = m_done;
    if (!rn) begin
      m_cyc = 0; m_done = 0; m_pass = 0; m_finish = 0; m_dump = 0;
      m_reason = 0; m_failch = 0; m_succ = 0; m_pass_at = -1;
      for (int i = 0; i < NUM_CH; i++) m_last_clear[i] = HOLDOFF - 1;
    end else begin
      if (!m_done && m_cyc >= HOLDOFF) begin
        stl = 0;
        old_succ = m_succ;
`ifdef RUN_MONITOR_STALL_EN
        for (int i = 0; i < NUM_CH; i++)
          if (cfg_stall_limit != 0 && !m_succ[i] &&
              (m_cyc - 1 - m_last_clear[i]) >= longint'(cfg_stall_limit))
            stl[i] = 1'b1;
`endif
        if (f != 0) begin
          m_done = 1; m_reason = 1; m_failch = f;
        end else if (cfg_max_cycles != 0 && m_cyc > longint'(cfg_max_cycles)) begin
          m_done = 1; m_reason = 2; m_failch = 0;
        end else if (stl != 0) begin
          m_done = 1; m_reason = 3; m_failch = stl;
        end else begin
          if (m_pass_at < 0) begin
            m_succ = m_succ | s;
            if (m_succ == 4'hF) m_pass_at = m_cyc + 1 + DRAIN;
          end
          if (m_pass_at == m_cyc + 1) begin
            m_done = 1; m_pass = 1; m_reason = 4;
          end
        end
        for (int i = 0; i < NUM_CH; i++)
          if (p[i] || old_succ[i]) m_last_clear[i] = m_cyc;
      end
      m_finish = m_done && !was_done;
      m_cyc++;
      m_dump = (m_cyc >= HOLDOFF || cfg_dump_start == 0) && m_cyc >= longint'(cfg_dump_start) &&
               (cfg_dump_stop == 0 || m_cyc < longint'(cfg_dump_stop)) && !m_done;
    end
  endtask

  task automatic check_output();
    logic [75:0] exp_v, act_v;
    exp_v = {(m_cyc < HOLDOFF), m_dump, 64'(m_cyc), m_done, m_pass, m_reason, m_failch, m_finish};
    act_v = {harness_reset, dump_en, cycle_count, done, pass, reason, fail_ch, finish_req};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL outputs@cyc%0d act=%h exp=%h (hr,dump,count,done,pass,reason,fail_ch,fin)",
               m_cyc, act_v, exp_v);
    end
  endtask

  task automatic check_value(input string name, input longint act, input longint exp_val);
    checks++;
    if (act != exp_val) begin
      errors++;
      $display("[TB] FAIL %s act=%0d exp=%0d", name, act, exp_val);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic apply_stimulus(input logic rn, input logic [3:0] s, input logic [3:0] f,
                                input logic [3:0] p);
    reset_n = rn; ch_success = s; ch_failure = f; ch_progress = p;
    model_step(rn, s, f, p);
    @(posedge clock);
    #1;
    check_output();
  endtask

  typedef struct {
    string      name;
    longint     max_cyc, dstart, dstop;
    int         slimit;
    int         succ_cyc;
    logic [3:0] succ_mask;
    int         fail_cyc;
    logic [3:0] fail_mask;
    int         stall_ch, stall_stop, len;
    int         exp_done_cyc;
    logic [2:0] exp_reason;
    logic [3:0] exp_failch;
    logic       exp_pass;
    int         exp_fin, exp_dump_first, exp_dump_cnt;
  } scen_t;

  scen_t tbl [6];

  task automatic run_scenario(input scen_t sc);
    int         first_done, fin, dfirst, dcnt;
    logic [3:0] s, f, p;
    cfg_max_cycles = 64'(sc.max_cyc); cfg_dump_start = 64'(sc.dstart);
    cfg_dump_stop = 64'(sc.dstop); cfg_stall_limit = 16'(sc.slimit);
    apply_stimulus(1'b0, 4'h0, 4'h0, 4'h0);
    first_done = -1; fin = 0; dfirst = -1; dcnt = 0;
    for (int c = 0; c < sc.len; c++) begin
      s = (sc.succ_cyc >= 0 && c >= sc.succ_cyc) ? sc.succ_mask : 4'h0;
      f = (c == sc.fail_cyc) ? sc.fail_mask : 4'h0;
      p = 4'hF;
      if (sc.stall_ch >= 0 && c >= sc.stall_stop) p[sc.stall_ch] = 1'b0;
      apply_stimulus(1'b1, s, f, p);
      if (done && first_done < 0) first_done = c + 1;
      if (finish_req) fin++;
      if (dump_en) begin
        if (dfirst < 0) dfirst = c + 1;
        dcnt++;
      end
    end
    check_value({sc.name, "_done_cycle"}, first_done, sc.exp_done_cyc);
    check_value({sc.name, "_reason"}, reason, sc.exp_reason);
    check_value({sc.name, "_fail_ch"}, fail_ch, sc.exp_failch);
    check_value({sc.name, "_pass"}, pass, sc.exp_pass);
    check_value({sc.name, "_finish_pulses"}, fin, sc.exp_fin);
    check_value({sc.name, "_dump_first"}, dfirst, sc.exp_dump_first);
    check_value({sc.name, "_dump_cycles"}, dcnt, sc.exp_dump_cnt);
  endtask

  initial begin
    int         hr_cnt;
    logic [3:0] s, f, p;

    //           name      max  dst  dstp lim scy mask fcy fmsk sch sst len  done rsn fch  pass fin dfirst dcnt
    tbl[0] = '{"pass",      0,   0,   0,  0, 100, 4'hF, -1, 4'h0, -1, 0, 150, 117, 3'd4, 4'h0, 1'b1, 1, 1, 116};
    tbl[1] = '{"failfirst", 0,   0,   0,  0,  50, 4'hF, 50, 4'h4, -1, 0,  80,  51, 3'd1, 4'h4, 1'b0, 1, 1, 50};
    tbl[2] = '{"timeout",  200, 10,   0,  0,  -1, 4'h0, -1, 4'h0, -1, 0, 260, 202, 3'd2, 4'h0, 1'b0, 1, 10, 192};
    tbl[3] = '{"notimeout", 0, 250, 260,  0,  -1, 4'h0, -1, 4'h0, -1, 0, 300,  -1, 3'd0, 4'h0, 1'b0, 0, 250, 10};
`ifdef RUN_MONITOR_STALL_EN
    tbl[4] = '{"stall",     0,   0,  45, 10,  -1, 4'h0, -1, 4'h0,  2, 40, 100, 51, 3'd3, 4'h4, 1'b0, 1, 1, 44};
`else
    tbl[4] = '{"stall",     0,   0,  45, 10,  -1, 4'h0, -1, 4'h0,  2, 40, 100, -1, 3'd0, 4'h0, 1'b0, 0, 1, 44};
`endif
    tbl[5] = '{"dumpwin",   0,  20,  30,  0,  -1, 4'h0, -1, 4'h0, -1, 0,  60,  -1, 3'd0, 4'h0, 1'b0, 0, 20, 10};

    for (int i = 0; i < 6; i++) begin
      $display("[TB] scenario %s", tbl[i].name);
      run_scenario(tbl[i]);
    end

    // Reset pulsed while draining towards a pass.
    $display("[TB] reset during drain");
    cfg_max_cycles = 0; cfg_dump_start = 0; cfg_dump_stop = 0; cfg_stall_limit = 0;
    apply_stimulus(1'b0, 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 110; c++)
      apply_stimulus(1'b1, (c >= 100) ? 4'hF : 4'h0, 4'h0, 4'hF);
    apply_stimulus(1'b0, 4'hF, 4'h0, 4'hF);
    check_value("rst_harness_reset", harness_reset, 1);
    check_value("rst_cycle_count", cycle_count, 0);
    check_value("rst_done", done, 0);
    check_value("rst_reason", reason, 0);
    check_value("rst_dump_en", dump_en, 0);
    hr_cnt = 1;
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(1'b1, 4'h0, 4'h0, 4'hF);
      if (c == 0) check_value("rst_count_restart", cycle_count, 1);
      if (harness_reset) hr_cnt++;
    end
    check_value("rst_holdoff_cycles", hr_cnt, HOLDOFF);
    check_value("rst_no_verdict", done, 0);

    // Randomized runs with occasional mid-run resets.
    for (int r = 0; r < 10; r++) begin
      cfg_max_cycles  = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(5, 350));
      cfg_dump_start  = 64'($urandom_range(0, 60));
      cfg_dump_stop   = ($urandom_range(0, 1) == 0) ? 64'd0 : 64'($urandom_range(0, 400));
      cfg_stall_limit = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(2, 8));
      $display("[TB] random run %0d max=%0d dump=%0d..%0d stall=%0d", r, cfg_max_cycles,
               cfg_dump_start, cfg_dump_stop, cfg_stall_limit);
      apply_stimulus(1'b0, 4'h0, 4'h0, 4'h0);
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          s[i] = ($urandom_range(0, 59) == 0);
          p[i] = ($urandom_range(0, 99) < 85);
        end
        f = ($urandom_range(0, 399) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        apply_stimulus(($urandom_range(0, 499) != 0), s, f, p);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
